// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the iteration counter width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width: max(1, clog2(width)), so WIDTH=1 still gets a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the bit-serial adder.
// Handshake: a request is accepted on a clock edge where start=1 and the block is
// idle (busy=0, done=0); start at any other time is dropped, never queued.
// done pulses for one cycle when sum/cout become valid; they then hold until the
// next accepted request completes.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit full adder built from two half adders; this is the single shared
// datapath cell that the serial controller steps through every bit.
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    halfadder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit unsigned adder: one fa_cell reused LSB-first over WIDTH
// cycles, with carry held between bits and a busy/done handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus,
    output state_t             state_dbg
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic             bit_s;
    logic             carry_n;
    logic [CW-1:0]    cnt;
    logic             last;

    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (carry_n)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // New bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_s_one
            assign s_next = bit_s;
        end else begin : g_s_wide
            assign s_next = {bit_s, s_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_RUN;
            ST_RUN:  if (last)      state_nx = ST_DONE;
            ST_DONE:                state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state == ST_RUN);
        bus.done  = (state == ST_DONE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    carry <= carry_n;
                    cnt   <= cnt + CW'(1);
                    // Results are published only once, on the final bit.
                    if (last) begin
                        sum_q  <= s_next;
                        cout_q <= carry_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
